bit_stream_serializer: RTL and testbench

- Upstream feeder for the Moore output FSM. Buffers parallel test words in a small FIFO and serializes them MSB-first, one bit per clock, onto the FSM's single-bit `in` input.
- A `hold` input lets the consumer or bench freeze the stream.
- `ser_last` marks word boundaries so the downstream checker can align expected `out`/`state` sequences.

---
 rtl/bit_stream_serializer.sv | 168 ++++++++++++++++
 tb/tb_bit_stream_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer
// Buffers parallel words in a small FIFO and serializes them MSB-first, one
// bit per unheld clock, for a downstream single-bit consumer. ser_last flags
// the LSB of each word so the consumer can align on word boundaries.
module bit_stream_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         hold,
   output logic                         ser_bit,
   output logic                         ser_valid,
   output logic                         ser_last,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = $clog2(WIDTH);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   // FIFO storage and bookkeeping
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Serializer state
   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_shift;
   logic [IW-1:0]    r_idx;
   logic             r_ser_bit;
   logic             r_ser_valid;
   logic             r_ser_last;

   // Control strobes
   logic             w_fifo_has;
   logic             w_push;
   logic             w_pop;
   logic             w_load;
   logic             w_step;
   logic             w_to_idle;
   logic [WIDTH-1:0] w_head;
   logic [IW-1:0]    w_idx_dn;

   // FIFO handshake: ready depends only on occupancy, never on a same-cycle pop
   always_comb begin
      w_fifo_has = (r_count != '0);
      in_ready   = !rst && (r_count != CW'(DEPTH));
      w_push     = in_valid && in_ready;
      w_pop      = w_load;
      w_head     = r_mem[r_rd_ptr];
      w_idx_dn   = r_idx - IW'(1);
   end

   // Next-state logic: decide between loading a word, stepping a bit, or going idle
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_to_idle    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fifo_has) begin
               w_load       = 1'b1;
               w_next_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (!hold) begin
               if (r_idx != '0) begin
                  w_step = 1'b1;
               end else if (w_fifo_has) begin
                  // gapless reload: the next word's MSB follows the current LSB directly
                  w_load = 1'b1;
               end else begin
                  w_to_idle    = 1'b1;
                  w_next_state = S_IDLE;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FIFO storage write; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Shifter datapath and registered serial outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift     <= '0;
         r_idx       <= '0;
         r_ser_bit   <= 1'b0;
         r_ser_valid <= 1'b0;
         r_ser_last  <= 1'b0;
      end else if (w_load) begin
         r_shift     <= w_head;
         r_idx       <= IW'(WIDTH - 1);
         r_ser_bit   <= w_head[WIDTH-1];
         r_ser_valid <= 1'b1;
         r_ser_last  <= 1'b0;
      end else if (w_step) begin
         r_idx       <= w_idx_dn;
         r_ser_bit   <= r_shift[w_idx_dn];
         r_ser_valid <= 1'b1;
         r_ser_last  <= (w_idx_dn == '0);
      end else if (w_to_idle) begin
         r_ser_bit   <= 1'b0;
         r_ser_valid <= 1'b0;
         r_ser_last  <= 1'b0;
      end
   end

   // Output mapping
   always_comb begin
      ser_bit    = r_ser_bit;
      ser_valid  = r_ser_valid;
      ser_last   = r_ser_last;
      fifo_count = r_count;
   end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: words are scoreboarded bit by bit
// when accepted and compared as the serial stream emerges.
`timescale 1ns/1ps
module tb_bit_stream_serializer;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       hold;
   logic       ser_bit;
   logic       ser_valid;
   logic       ser_last;
   logic [2:0] fifo_count;

   int checks;
   int errors;
   int valid_cycles;

   // expected stream entries: {bit, last}
   logic [1:0] exp_q[$];

   bit_stream_serializer #(
      .WIDTH(8),
      .DEPTH(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .hold      (hold),
      .ser_bit   (ser_bit),
      .ser_valid (ser_valid),
      .ser_last  (ser_last),
      .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive a word and hold it until accepted; bits are queued at the accepting edge.
   task automatic push_word(input logic [7:0] w);
      logic ok;
      ok       = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (in_ready) begin
            for (int b = 7; b >= 0; b--) exp_q.push_back({w[b], (b == 0)});
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("push_accept", ok, 1);
   endtask

   // Wait (bounded) for the stream to empty out, then confirm FIFO is empty.
   task automatic drain();
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !ser_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain", ok, 1);
      check("drain_count", fifo_count, 0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: one bit is consumed per unheld valid cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (ser_valid) begin
            valid_cycles++;
            if (!hold) begin
               check("sb_underflow", (exp_q.size() == 0), 0);
               if (exp_q.size() != 0) begin
                  logic [1:0] e;
                  e = exp_q.pop_front();
                  check("ser_bit", ser_bit, e[1]);
                  check("ser_last", ser_last, e[0]);
               end
            end
         end else begin
            check("idle_bit", ser_bit, 0);
            check("idle_last", ser_last, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      valid_cycles = 0;
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_data      = '0;
      hold         = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", ser_valid, 0);
      check("rst_bit", ser_bit, 0);
      check("rst_last", ser_last, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", in_ready, 1);

      // Single word with latency check
      push_word(8'hB4);
      check("single_count_e", fifo_count, 1);
      check("single_valid_e", ser_valid, 0);
      @(posedge clk); #1;
      check("single_valid_e1", ser_valid, 1);
      check("single_msb", ser_bit, 1);
      check("single_count_e1", fifo_count, 0);
      repeat (6) @(posedge clk);
      #1;
      check("single_last_e7", ser_last, 0);
      @(posedge clk); #1;
      check("single_last_e8", ser_last, 1);
      check("single_valid_e8", ser_valid, 1);
      @(posedge clk); #1;
      check("single_valid_e9", ser_valid, 0);
      drain();

      // Back-to-back words, gapless
      push_word(8'hFF);
      push_word(8'h00);
      check("b2b_count", fifo_count, 1);
      for (int i = 0; i < 16; i++) begin
         check("b2b_valid", ser_valid, 1);
         check("b2b_bit", ser_bit, (i < 8) ? 1 : 0);
         check("b2b_last", ser_last, (i == 7 || i == 15) ? 1 : 0);
         @(posedge clk); #1;
      end
      check("b2b_end_valid", ser_valid, 0);
      drain();

      // Full FIFO with hold asserted
      push_word(8'hA1);
      @(posedge clk); #1;
      check("full_loaded", ser_valid, 1);
      hold = 1'b1;
      push_word(8'hC3);
      push_word(8'h3C);
      push_word(8'h96);
      push_word(8'hE7);
      check("full_count", fifo_count, 4);
      check("full_ready", in_ready, 0);
      in_data  = 8'h18;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("full_count_held", fifo_count, 4);
         check("full_ready_held", in_ready, 0);
         check("full_bit_held", ser_bit, 1);
      end
      hold = 1'b0;
      push_word(8'h18);
      drain();

      // Hold during bit 5 of 8'hB4
      valid_cycles = 0;
      push_word(8'hB4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("hold_pre_bit5", ser_bit, 1);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("hold_bit", ser_bit, 1);
         check("hold_valid", ser_valid, 1);
         check("hold_last", ser_last, 0);
      end
      hold = 1'b0;
      drain();
      check("hold_valid_cycles", valid_cycles, 11);

      // Reset in the middle of a word with buffered words behind it
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      repeat (3) @(posedge clk);
      #1;
      check("mid_valid", ser_valid, 1);
      check("mid_bit3", ser_bit, 0);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_ready", in_ready, 0);
      @(posedge clk); #1;
      check("mid_rst_valid", ser_valid, 0);
      check("mid_rst_bit", ser_bit, 0);
      check("mid_rst_last", ser_last, 0);
      check("mid_rst_count", fifo_count, 0);
      rst = 1'b0;
      @(negedge clk);
      check("mid_ready_after", in_ready, 1);
      @(posedge clk); #1;
      check("mid_no_stale", ser_valid, 0);
      push_word(8'h81);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
